// File: rtl/rcn_pkg.sv
// rcn_pkg: RCN ring packet field positions and GPIO register offsets
package rcn_pkg;
   localparam int RCN_W   = 69;
   localparam int VALID   = 68;
   localparam int PEND    = 67;
   localparam int WR      = 66;
   localparam int ID_HI   = 65;
   localparam int ID_LO   = 60;
   localparam int MASK_HI = 59;
   localparam int MASK_LO = 56;
   localparam int ADDR_HI = 55;
   localparam int ADDR_LO = 34;
   localparam int SEQ_HI  = 33;
   localparam int SEQ_LO  = 32;
   localparam int DATA_HI = 31;
   localparam int DATA_LO = 0;
   localparam logic [1:0] GPI     = 2'd0;
   localparam logic [1:0] GPO     = 2'd1;
   localparam logic [1:0] EDGE    = 2'd2;
   localparam logic [1:0] EDGE_EN = 2'd3;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: 2-flop input synchronizer with history flop for rising-edge detection
module gpio_sync_edge #(
   parameter logic [31:0] RESET_VAL = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] gpi,
   output logic [31:0] sync,
   output logic [31:0] rise
);
   logic [31:0] meta_q, meta_d, sync_q, sync_d, hist_q, hist_d;
   always_comb begin
      meta_d = gpi;
      sync_d = meta_q;
      hist_d = sync_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
         hist_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end
   assign sync = sync_q;
   assign rise = sync_q & ~hist_q;
endmodule

// File: rtl/rcn_gpio.sv
// rcn_gpio: RCN ring GPIO responder with byte-masked GPO, edge capture and level irq
module rcn_gpio
   import rcn_pkg::*;
#(
   parameter logic [23:0] ADDR_BASE = 24'hFFFFC0,
   parameter logic [31:0] GPI_RESET = 32'd0,
   parameter logic [31:0] GPO_RESET = 32'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RCN_W-1:0] rcn_in,
   output logic [RCN_W-1:0] rcn_out,
   input  logic [31:0]      gpi,
   output logic [31:0]      gpo,
   output logic             irq
);
   logic [RCN_W-1:0] rcn_out_q, rcn_out_d;
   logic [31:0] gpo_q, gpo_d, edge_q, edge_d, edge_en_q, edge_en_d;
   logic        irq_q, irq_d;
   logic [31:0] sync, rise, wdata, bm, rd_data;
   logic [3:0]  m;
   logic [1:0]  sel;
   logic        hit, we;
   gpio_sync_edge #(.RESET_VAL(GPI_RESET)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .gpi  (gpi),
      .sync (sync),
      .rise (rise)
   );
   always_comb begin
      hit = rcn_in[VALID] && rcn_in[PEND] && rcn_in[ADDR_HI:ADDR_LO+2] == ADDR_BASE[23:4];
      we = hit && rcn_in[WR];
      sel = rcn_in[ADDR_LO+1:ADDR_LO];
      wdata = rcn_in[DATA_HI:DATA_LO];
      m = rcn_in[MASK_HI:MASK_LO];
      bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      rd_data = sel == GPI ? sync : sel == GPO ? gpo_q : sel == EDGE ? edge_q : edge_en_q;
      gpo_d = we && sel == GPO ? (gpo_q & ~bm) | (wdata & bm) : gpo_q;
      // a rise in the same cycle as a clear wins
      edge_d = (edge_q & ~(we && sel == EDGE ? wdata & bm : 32'd0)) | rise;
      edge_en_d = we && sel == EDGE_EN ? (edge_en_q & ~bm) | (wdata & bm) : edge_en_q;
      irq_d = |(edge_q & edge_en_q);
      rcn_out_d = hit ? {1'b1, 1'b0, rcn_in[WR:SEQ_LO], rcn_in[WR] ? wdata : rd_data} : rcn_in;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rcn_out_q <= '0;
         gpo_q     <= GPO_RESET;
         edge_q    <= '0;
         edge_en_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         rcn_out_q <= rcn_out_d;
         gpo_q     <= gpo_d;
         edge_q    <= edge_d;
         edge_en_q <= edge_en_d;
         irq_q     <= irq_d;
      end
   end
   assign rcn_out = rcn_out_q;
   assign gpo = gpo_q;
   assign irq = irq_q;
endmodule

// File: tb/tb_rcn_gpio.sv
// tb_rcn_gpio: directed stimulus checked against a cycle model of the GPIO responder
module tb_rcn_gpio;
   localparam logic [23:0] BASE = 24'hFFFFC0;
   logic        clk = 0, rst = 1;
   logic [68:0] rcn_in = '0, rcn_out;
   logic [31:0] gpi = '0, gpo;
   logic        irq;
   int checks = 0, errors = 0;

   rcn_gpio #(.ADDR_BASE(BASE), .GPI_RESET(32'd0), .GPO_RESET(32'd0)) dut (
      .clk(clk), .rst(rst), .rcn_in(rcn_in), .rcn_out(rcn_out),
      .gpi(gpi), .gpo(gpo), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [68:0] pkt(input bit v, input bit p, input bit w, input logic [5:0] id,
                                       input logic [3:0] m, input logic [23:0] a,
                                       input logic [1:0] s, input logic [31:0] d);
      return {v, p, w, id, m, a[23:2], s, d};
   endfunction

   // model: gpi samples from the last three edges, registers as plain words
   logic [68:0] exp_out;
   logic [31:0] m_gpo, m_edge, m_en, t_bm, t_rd, t_rise;
   logic [31:0] g [3];
   logic [23:0] t_a;
   logic        m_irq, t_hit;
   int          t_off;
   bit          armed = 0;

   always @(posedge clk) begin
      if (rst) begin
         armed = 1;
         exp_out = '0; m_gpo = '0; m_edge = '0; m_en = '0; m_irq = 0;
         g[0] = '0; g[1] = '0; g[2] = '0;
      end else begin
         t_rise = g[1] & ~g[2];
         m_irq = (m_edge & m_en) != 0;
         t_a = {rcn_in[55:34], 2'b00};
         t_off = int'(t_a) - int'(BASE);
         t_hit = rcn_in[68] && rcn_in[67] && t_off >= 0 && t_off < 16;
         t_bm = '0;
         for (int b = 0; b < 4; b++) if (rcn_in[56+b]) t_bm = t_bm | (32'hFF << (8*b));
         t_rd = t_off == 0 ? g[1] : t_off == 4 ? m_gpo : t_off == 8 ? m_edge : m_en;
         if (t_hit) begin
            exp_out = {2'b10, rcn_in[66:32], rcn_in[66] ? rcn_in[31:0] : t_rd};
            if (rcn_in[66]) begin
               if (t_off == 4) m_gpo = (m_gpo & ~t_bm) | (rcn_in[31:0] & t_bm);
               if (t_off == 8) m_edge = m_edge & ~(rcn_in[31:0] & t_bm);
               if (t_off == 12) m_en = (m_en & ~t_bm) | (rcn_in[31:0] & t_bm);
            end
         end else exp_out = rcn_in;
         m_edge = m_edge | t_rise;
         g[2] = g[1]; g[1] = g[0]; g[0] = gpi;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("model rcn_out", rcn_out, exp_out);
         chk("model gpo", {37'd0, gpo}, {37'd0, m_gpo});
         chk("model irq", {68'd0, irq}, {68'd0, m_irq});
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic xfer(input logic [68:0] p, output logic [68:0] r);
      rcn_in = p;
      tick;
      r = rcn_out;
      rcn_in = '0;
   endtask

   logic [68:0] r, p;
   logic [31:0] d;

   initial begin
      repeat (3) tick;
      chk("reset rcn_out", rcn_out, 69'd0);
      chk("reset gpo", {37'd0, gpo}, 69'd0);
      chk("reset irq", {68'd0, irq}, 69'd0);
      rst = 0;
      tick;
      xfer(pkt(1, 1, 1, 6'h01, 4'b0011, BASE + 4, 2'd2, 32'h0000A55A), r);
      chk("t1 response", r, pkt(1, 0, 1, 6'h01, 4'b0011, BASE + 4, 2'd2, 32'h0000A55A));
      chk("t1 gpo", {37'd0, gpo}, {37'd0, 32'h0000A55A});
      xfer(pkt(1, 1, 1, 6'h01, 4'b1000, BASE + 4, 2'd3, 32'hFFFFFFFF), r);
      chk("t1 gpo upper", {37'd0, gpo}, {37'd0, 32'hFF00A55A});
      gpi = 32'h12345678;
      repeat (4) tick;
      xfer(pkt(1, 1, 0, 6'h02, 4'hF, BASE, 2'd0, 32'h0), r);
      chk("t2 gpi read", r, pkt(1, 0, 0, 6'h02, 4'hF, BASE, 2'd0, 32'h12345678));
      xfer(pkt(1, 1, 0, 6'h02, 4'hF, BASE + 8, 2'd1, 32'h0), r);
      chk("t2 edge read", {37'd0, r[31:0]}, {37'd0, 32'h12345678});
      xfer(pkt(1, 1, 1, 6'h03, 4'hF, BASE + 8, 2'd0, 32'hFFFFFFFF), r);
      xfer(pkt(1, 1, 1, 6'h03, 4'hF, BASE + 12, 2'd1, 32'h1), r);
      gpi = 32'h12345679;
      repeat (3) tick;
      chk("t3 irq not yet", {68'd0, irq}, 69'd0);
      tick;
      chk("t3 irq set", {68'd0, irq}, 69'd1);
      xfer(pkt(1, 1, 1, 6'h03, 4'b0001, BASE + 8, 2'd2, 32'h1), r);
      chk("t3 irq at w1c rsp", {68'd0, irq}, 69'd1);
      tick;
      chk("t3 irq cleared", {68'd0, irq}, 69'd0);
      gpi = 32'h12345678;
      repeat (4) tick;
      gpi = 32'h12345679;
      tick;
      tick;
      xfer(pkt(1, 1, 1, 6'h04, 4'b0001, BASE + 8, 2'd0, 32'h1), r);
      xfer(pkt(1, 1, 0, 6'h04, 4'hF, BASE + 8, 2'd1, 32'h0), r);
      chk("t4 set wins", {37'd0, r[31:0]}, {37'd0, 32'h1});
      p = pkt(1, 1, 1, 6'h05, 4'hF, BASE + 24'h10, 2'd1, 32'hDEADBEEF);
      xfer(p, r);
      chk("t5 miss addr", r, p);
      p = pkt(1, 0, 0, 6'h06, 4'hF, BASE, 2'd2, 32'h0BADF00D);
      xfer(p, r);
      chk("t5 response fwd", r, p);
      xfer(69'd0, r);
      chk("t5 idle", r, 69'd0);
      for (int i = 0; i < 8; i++) begin
         d = 32'hC0DE0000 + 32'(i / 2);
         rcn_in = pkt(1, 1, i % 2 == 0, 6'(i), 4'hF, BASE + 4, 2'(i), (i % 2 == 0) ? d : 32'h0);
         tick;
         chk("t6 b2b", rcn_out, pkt(1, 0, i % 2 == 0, 6'(i), 4'hF, BASE + 4, 2'(i), d));
      end
      rcn_in = pkt(1, 1, 1, 6'h07, 4'hF, BASE + 4, 2'd0, 32'h55555555);
      rst = 1;
      tick;
      chk("t6 rst drop", rcn_out, 69'd0);
      chk("t6 rst gpo", {37'd0, gpo}, 69'd0);
      chk("t6 rst irq", {68'd0, irq}, 69'd0);
      rcn_in = '0;
      rst = 0;
      xfer(pkt(1, 1, 0, 6'h08, 4'hF, BASE + 12, 2'd0, 32'h0), r);
      chk("t6 rst edge_en", r, pkt(1, 0, 0, 6'h08, 4'hF, BASE + 12, 2'd0, 32'h0));
      repeat (3) tick;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
